// File: rtl/accum_capture_pkg.sv
// Shared definitions for the accumulator result capture block: default
// widths, controller state encoding and the buffered snapshot entry layout.
package accum_capture_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WINDOW_LEN  = 16;
    localparam int DEF_FIFO_DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } capture_state_t;

    // One buffered snapshot at the default width. Snapshot sits in the upper
    // half so a packed {snapshot, delta} vector maps onto it directly.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] snapshot;
        logic [DEF_DATA_W-1:0] delta;
    } capture_entry_t;

endpackage

// File: rtl/capture_fifo.sv
// First-word-fall-through snapshot buffer. The head is visible combinationally
// from storage one cycle after the push edge. When empty, the last popped
// word is held on the head so downstream sees stable values.
module capture_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             empty;
    logic             full;
    logic             pop_acc;
    logic             push_acc;

    // Accept/drop decisions; a push into a full buffer is only taken when the
    // head leaves in the same cycle, since the freed slot is the one written.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        pop_acc  = pop && !empty;
        push_acc = push && (!full || pop_acc);
        drop     = push && full && !pop_acc;
    end

    // Next-state for pointers, occupancy and the held-last-word register.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage array; never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Head presentation: live entry when occupied, otherwise the last one out.
    always_comb begin
        head_valid = !empty;
        head_data  = empty ? last_q : mem_q[rd_ptr_q];
        count      = count_q;
    end

endmodule

// File: rtl/accum_result_capture.sv
// Windowed snapshot capture of an upstream running sum. Every WINDOW_LEN
// counted cycles the current sum and its difference from the previous
// snapshot are pushed into a small FWFT buffer for a downstream consumer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | capture disabled; window counter holds its value
// RUN   | capture enabled, upstream adder active; cycles are counted
// STALL | capture enabled, upstream adder bypassed; counter holds
module accum_result_capture
    import accum_capture_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WINDOW_LEN = DEF_WINDOW_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          capture_reset,
    input  logic [DATA_W-1:0]             added_result,
    input  logic                          adder_bypass,
    input  logic                          capture_enable,
    output logic [DATA_W-1:0]             result_data,
    output logic [DATA_W-1:0]             result_delta,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic                          window_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow_flag
);

    localparam int                CNT_W    = $clog2(WINDOW_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WINDOW_LEN - 1);
    localparam int                ENTRY_W  = 2 * DATA_W;

    capture_state_t      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                window_done_q, window_done_d;
    logic                overflow_q, overflow_d;

    logic                count_en;
    logic                boundary;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic                head_valid;
    logic                fifo_drop;

    // State register.
    always_ff @(posedge clk) begin
        if (capture_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: disabling capture always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!capture_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = adder_bypass ? STALL : RUN;
                STALL:   state_d = adder_bypass ? STALL : RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counting qualifier taken straight from the inputs so the first enabled
    // cycle out of IDLE already counts; the state only lags these inputs.
    always_comb begin
        count_en = capture_enable && !adder_bypass;
        boundary = count_en && (cnt_q == CNT_LAST);
    end

    // Window counter, previous-snapshot tracking and status flags.
    always_comb begin
        cnt_d         = cnt_q;
        prev_d        = prev_q;
        window_done_d = boundary;
        overflow_d    = overflow_q | fifo_drop;
        if (count_en) begin
            cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
        end
        // Previous snapshot advances even when the entry itself is dropped,
        // so the next delta spans exactly one window.
        if (boundary) begin
            prev_d = added_result;
        end
        push_entry = {added_result, added_result - prev_q};
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (capture_reset) begin
            cnt_q         <= '0;
            prev_q        <= '0;
            window_done_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            window_done_q <= window_done_d;
            overflow_q    <= overflow_d;
        end
    end

    capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (capture_reset),
        .push       (boundary),
        .push_data  (push_entry),
        .pop        (result_ready),
        .head_data  (head_entry),
        .head_valid (head_valid),
        .count      (fifo_count),
        .drop       (fifo_drop)
    );

    // Output unpacking.
    always_comb begin
        result_data   = head_entry[ENTRY_W-1:DATA_W];
        result_delta  = head_entry[DATA_W-1:0];
        result_valid  = head_valid;
        window_done   = window_done_q;
        overflow_flag = overflow_q;
    end

endmodule

// File: tb/tb_accum_result_capture.sv
// Directed and randomised-ready checks of accum_result_capture with
// WINDOW_LEN=4 and FIFO_DEPTH=8.
module tb_accum_result_capture;
    import accum_capture_pkg::*;

    localparam int DW = 32;
    localparam int WL = 4;
    localparam int FD = 8;
    localparam int CW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          capture_reset;
    logic [DW-1:0] added_result;
    logic          adder_bypass;
    logic          capture_enable;
    logic [DW-1:0] result_data;
    logic [DW-1:0] result_delta;
    logic          result_valid;
    logic          result_ready;
    logic          window_done;
    logic [CW-1:0] fifo_count;
    logic          overflow_flag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    accum_result_capture #(
        .DATA_W     (DW),
        .WINDOW_LEN (WL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .capture_reset  (capture_reset),
        .added_result   (added_result),
        .adder_bypass   (adder_bypass),
        .capture_enable (capture_enable),
        .result_data    (result_data),
        .result_delta   (result_delta),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .window_done    (window_done),
        .fifo_count     (fifo_count),
        .overflow_flag  (overflow_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        capture_reset  = 1'b1;
        capture_enable = 1'b0;
        adder_bypass   = 1'b0;
        result_ready   = 1'b0;
        added_result   = '0;
        tick();
        tick();
        capture_reset = 1'b0;
    endtask

    task automatic test_reset();
        capture_reset  = 1'b1;
        capture_enable = 1'b1;
        adder_bypass   = 1'b0;
        result_ready   = 1'b1;
        added_result   = 32'hDEAD_BEEF;
        tick();
        tick();
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", result_valid); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (result_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", result_data); end
        total++; if (result_delta !== '0) begin bad++; $display("FAIL reset_delta got=%h want=0", result_delta); end
        total++; if (window_done !== 1'b0) begin bad++; $display("FAIL reset_wdone got=%b want=0", window_done); end
        total++; if (overflow_flag !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow_flag); end
        capture_reset = 1'b0;
    endtask

    task automatic test_basic();
        logic exp_wd;
        do_reset();
        capture_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            added_result = 32'(10 * (i + 1));
            tick();
            exp_wd = (i == 3);
            total++; if (window_done !== exp_wd) begin bad++; $display("FAIL basic_wdone edge=%0d got=%b want=%b", i + 1, window_done, exp_wd); end
        end
        total++; if (fifo_count !== CW'(1)) begin bad++; $display("FAIL basic_count got=%0d want=1", fifo_count); end
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", result_valid); end
        total++; if (result_data !== 32'd40) begin bad++; $display("FAIL basic_data got=%0d want=40", result_data); end
        total++; if (result_delta !== 32'd40) begin bad++; $display("FAIL basic_delta got=%0d want=40", result_delta); end
        capture_enable = 1'b0;
        tick();
        total++; if (window_done !== 1'b0) begin bad++; $display("FAIL basic_pulse_end got=%b want=0", window_done); end
        total++; if (fifo_count !== CW'(1)) begin bad++; $display("FAIL basic_hold_count got=%0d want=1", fifo_count); end
        result_ready = 1'b1;
        tick();
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL basic_pop_valid got=%b want=0", result_valid); end
        total++; if (result_data !== 32'd40) begin bad++; $display("FAIL basic_empty_hold got=%0d want=40", result_data); end
        tick();
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL basic_empty_ready got=%0d want=0", fifo_count); end
    endtask

    task automatic test_bypass();
        do_reset();
        capture_enable = 1'b1;
        added_result = 32'd10; tick();
        added_result = 32'd20; tick();
        adder_bypass = 1'b1;
        for (int i = 0; i < 3; i++) begin
            added_result = 32'(21 + i);
            tick();
            total++; if (fifo_count !== '0 || window_done !== 1'b0) begin bad++; $display("FAIL bypass_hold cyc=%0d count=%0d wdone=%b want 0/0", i, fifo_count, window_done); end
        end
        adder_bypass = 1'b0;
        added_result = 32'd30; tick();
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL bypass_early got=%0d want=0", fifo_count); end
        added_result = 32'd40; tick();
        total++; if (fifo_count !== CW'(1) || window_done !== 1'b1) begin bad++; $display("FAIL bypass_snap count=%0d wdone=%b want 1/1", fifo_count, window_done); end
        total++; if (result_data !== 32'd40 || result_delta !== 32'd40) begin bad++; $display("FAIL bypass_value data=%0d delta=%0d want 40/40", result_data, result_delta); end
    endtask

    task automatic test_wrap();
        do_reset();
        capture_enable = 1'b1;
        added_result = 32'hFFFF_FFF0;
        repeat (4) tick();
        added_result = 32'h0000_0010;
        repeat (4) tick();
        capture_enable = 1'b0;
        total++; if (fifo_count !== CW'(2)) begin bad++; $display("FAIL wrap_count got=%0d want=2", fifo_count); end
        total++; if (result_data !== 32'hFFFF_FFF0 || result_delta !== 32'hFFFF_FFF0) begin bad++; $display("FAIL wrap_first data=%h delta=%h want fffffff0/fffffff0", result_data, result_delta); end
        result_ready = 1'b1;
        tick();
        total++; if (result_data !== 32'h0000_0010 || result_delta !== 32'h0000_0020) begin bad++; $display("FAIL wrap_second data=%h delta=%h want 00000010/00000020", result_data, result_delta); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_data  [8];
        logic [DW-1:0] exp_delta [8];
        do_reset();
        capture_enable = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            added_result = 32'(k * 100);
            repeat (4) tick();
        end
        total++; if (fifo_count !== CW'(8)) begin bad++; $display("FAIL ovf_count got=%0d want=8", fifo_count); end
        total++; if (overflow_flag !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow_flag); end
        total++; if (result_data !== 32'd100 || result_delta !== 32'd100) begin bad++; $display("FAIL ovf_head data=%0d delta=%0d want 100/100", result_data, result_delta); end
        added_result = 32'd1050;
        repeat (3) tick();
        result_ready = 1'b1;
        tick();
        total++; if (fifo_count !== CW'(8)) begin bad++; $display("FAIL ovf_pushpop_count got=%0d want=8", fifo_count); end
        capture_enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_data[i]  = 32'((i + 2) * 100);
            exp_delta[i] = 32'd100;
        end
        exp_data[7]  = 32'd1050;
        exp_delta[7] = 32'd150;
        for (int i = 0; i < 8; i++) begin
            total++; if (result_data !== exp_data[i] || result_delta !== exp_delta[i]) begin bad++; $display("FAIL ovf_drain idx=%0d data=%0d delta=%0d want %0d/%0d", i, result_data, result_delta, exp_data[i], exp_delta[i]); end
            tick();
        end
        total++; if (fifo_count !== '0 || overflow_flag !== 1'b1) begin bad++; $display("FAIL ovf_sticky count=%0d flag=%b want 0/1", fifo_count, overflow_flag); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        capture_enable = 1'b1;
        for (int k = 7; k <= 9; k++) begin
            added_result = 32'(k);
            repeat (4) tick();
        end
        repeat (2) tick();
        total++; if (fifo_count !== CW'(3)) begin bad++; $display("FAIL mid_pre_count got=%0d want=3", fifo_count); end
        capture_reset = 1'b1;
        tick();
        total++; if (result_valid !== 1'b0 || fifo_count !== '0) begin bad++; $display("FAIL mid_rst valid=%b count=%0d want 0/0", result_valid, fifo_count); end
        total++; if (result_data !== '0 || result_delta !== '0 || window_done !== 1'b0 || overflow_flag !== 1'b0) begin bad++; $display("FAIL mid_rst_out data=%h delta=%h wd=%b ovf=%b want all 0", result_data, result_delta, window_done, overflow_flag); end
        capture_reset = 1'b0;
        added_result = 32'd55;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (fifo_count !== '0) begin bad++; $display("FAIL mid_early cyc=%0d got=%0d want=0", i, fifo_count); end
        end
        tick();
        total++; if (fifo_count !== CW'(1) || result_data !== 32'd55 || result_delta !== 32'd55) begin bad++; $display("FAIL mid_snap count=%0d data=%0d delta=%0d want 1/55/55", fifo_count, result_data, result_delta); end
    endtask

    task automatic test_random();
        capture_entry_t q[$];
        capture_entry_t e;
        int            cnt_m   = 0;
        int            windows = 0;
        int            drops   = 0;
        int            cyc     = 0;
        logic          ovf_m   = 1'b0;
        logic          stall_prev = 1'b0;
        logic          pop, bnd;
        logic [DW-1:0] prev_m  = '0;
        logic [DW-1:0] last_d  = '0;
        logic [DW-1:0] last_dl = '0;
        do_reset();
        capture_enable = 1'b1;
        while (windows < 50 && cyc < 2000) begin
            added_result = $urandom;
            adder_bypass = ($urandom_range(0, 3) == 0);
            result_ready = ($urandom_range(0, 7) < ((cyc / 100) % 2 == 0 ? 1 : 5));
            if (stall_prev) begin
                total++; if (result_data !== last_d || result_delta !== last_dl) begin bad++; $display("FAIL rnd_stable cyc=%0d data=%h delta=%h want %h/%h", cyc, result_data, result_delta, last_d, last_dl); end
            end
            total++; if (result_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, result_valid, q.size() != 0); end
            pop = result_ready && (q.size() != 0);
            if (pop) begin
                total++; if (result_data !== q[0].snapshot || result_delta !== q[0].delta) begin bad++; $display("FAIL rnd_pop cyc=%0d data=%h delta=%h want %h/%h", cyc, result_data, result_delta, q[0].snapshot, q[0].delta); end
            end
            bnd = !adder_bypass && (cnt_m == WL - 1);
            if (!adder_bypass) cnt_m = bnd ? 0 : cnt_m + 1;
            stall_prev = result_valid && !result_ready;
            last_d  = result_data;
            last_dl = result_delta;
            if (pop) void'(q.pop_front());
            if (bnd) begin
                e.snapshot = added_result;
                e.delta    = added_result - prev_m;
                prev_m     = added_result;
                windows++;
                if (q.size() == FD) begin
                    drops++;
                    ovf_m = 1'b1;
                end else begin
                    q.push_back(e);
                end
            end
            tick();
            cyc++;
            total++; if (fifo_count !== CW'(q.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, fifo_count, q.size()); end
        end
        total++; if (windows < 50) begin bad++; $display("FAIL rnd_timeout windows=%0d want=50", windows); end
        total++; if (overflow_flag !== ovf_m) begin bad++; $display("FAIL rnd_ovf got=%b want=%b drops=%0d", overflow_flag, ovf_m, drops); end
    endtask

    initial begin
        capture_reset  = 1'b1;
        capture_enable = 1'b0;
        adder_bypass   = 1'b0;
        result_ready   = 1'b0;
        added_result   = '0;
        test_reset();
        test_basic();
        test_bypass();
        test_wrap();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_result_capture.md
ACCUM_RESULT_CAPTURE -- requirements
Module: accum_result_capture

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, accumulator data width; WINDOW_LEN, 16, counted cycles per snapshot window (2..65535); FIFO_DEPTH, 8, snapshot buffer entries (power of 2, >=2).
REQ-002 Ports SHALL be: clk  in  1  single clock, all logic rising-edge; capture_reset  in  1  synchronous, active-high reset.
REQ-003 Ports SHALL be: added_result  in  DATA_W  running sum from the upstream accumulator; adder_bypass  in  1  upstream bypass indicator; capture_enable  in  1  window counting enable.
REQ-004 Ports SHALL be: result_data  out  DATA_W  head snapshot; result_delta  out  DATA_W  head snapshot minus previous snapshot; result_valid  out  1  head entry present; result_ready  in  1  consumer accepts head.
REQ-005 Ports SHALL be: window_done  out  1  one-cycle pulse per window boundary; fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held; overflow_flag  out  1  sticky snapshot-dropped flag.

Function
REQ-006 FSM SHALL have states IDLE, RUN, STALL; IDLE->RUN when capture_enable=1; RUN->STALL when adder_bypass=1; STALL->RUN when adder_bypass=0; any state->IDLE when capture_enable=0.
REQ-007 A cycle SHALL be counted only when capture_enable=1 and adder_bypass=0; window counter SHALL hold in STALL and IDLE and SHALL NOT clear on IDLE entry.
REQ-008 On a counted cycle with counter=WINDOW_LEN-1: counter wraps to 0, added_result sampled that edge is the snapshot, window_done pulses high the next cycle.
REQ-009 result_delta SHALL equal snapshot minus previous snapshot, modulo 2^DATA_W (wrap, no saturation); previous-snapshot register starts at 0, so first delta equals first snapshot.
REQ-010 Previous-snapshot register SHALL update on every window boundary, including boundaries whose entry is dropped.
REQ-011 Buffer SHALL be first-word-fall-through: result_valid=(fifo_count!=0); result_data/result_delta show the oldest entry; pop on result_valid & result_ready.
REQ-012 Snapshot latency SHALL be one cycle: entry pushed at edge N is visible on outputs after edge N when buffer was empty.
REQ-013 Full, push without pop: entry SHALL be dropped, overflow_flag set, fifo_count stays FIFO_DEPTH.
REQ-014 Full, push with simultaneous pop: push SHALL be accepted, fifo_count unchanged, no overflow.
REQ-015 Empty: result_ready ignored; no pop; outputs hold last values.
REQ-016 Outputs SHALL remain stable while result_valid=1 and result_ready=0.

Reset
REQ-017 capture_reset=1 at a clock edge SHALL set: state IDLE, window counter 0, previous snapshot 0, buffer empty, fifo_count 0, result_valid 0, result_data 0, result_delta 0, window_done 0, overflow_flag 0.
REQ-018 Reset mid-window or with buffered entries SHALL discard all partial counts and entries; first snapshot after release requires a full WINDOW_LEN counted cycles.
REQ-019 overflow_flag SHALL clear only via capture_reset.

Structure
REQ-020 Shared package accum_capture_pkg SHALL hold DATA_W default, the state enum (IDLE/RUN/STALL), and the entry typedef {snapshot, delta}.
REQ-021 Buffer SHALL be a sub-module capture_fifo (parameterised depth/width, FWFT, count output); FSM, counter and delta logic live in accum_result_capture.

Verification
REQ-022 WINDOW_LEN=4, enable=1, bypass=0, added_result=10,20,30,40 per cycle -> one entry snapshot=40, delta=40; window_done pulses once, the cycle after the 4th edge.
REQ-023 Same as 022 with bypass=1 for 3 cycles after the 2nd count -> snapshot taken on the 4th counted cycle, i.e. 3 cycles later; counter held during bypass.
REQ-024 Snapshots 0xFFFF_FFF0 then 0x0000_0010 -> second delta=0x0000_0020.
REQ-025 FIFO_DEPTH=8, result_ready=0, 9 windows -> fifo_count=8, overflow_flag=1, head=first snapshot; 10th window with result_ready=1 on push edge -> count stays 8, no drop.
REQ-026 Reset asserted with 3 entries and counter=2 -> next cycle all outputs 0, result_valid=0; after release snapshot needs 4 counted cycles.
REQ-027 Random result_ready toggling over 50 windows -> outputs stable while stalled; popped sequence matches pushed sequence minus recorded drops.
